uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmit path among N on-chip byte requesters. It sequences the UART core's CSN/WEN/DATA_IN write strobe and paces writes off TXRDY, so that no requester talks to the core directly. It sits between the requesters (CPU bridge, debug logger, status streamer, etc.) and the UART core instance in the system block.

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that serialises N byte requesters onto one UART core write port.
// Optional packet lock (no interleaving until REQ_LAST) is enabled by defining UART_TX_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [8*NUM_REQ-1:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]     REQ_LAST,
  output logic [NUM_REQ-1:0]     ACK,
  output logic [NUM_REQ-1:0]     GRANT,
  output logic                   UART_CSN,
  output logic                   UART_WEN,
  output logic [7:0]             UART_DATA_IN,
  input  logic                   UART_TXRDY,
  output logic                   BUSY
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, WRITE, SETTLE, WAIT_RDY} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, sel, idx, nxt;
  logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d, elig;
  logic csn_q, csn_d, wen_q, wen_d, found;
  logic [7:0] data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic lock_q, lock_d, last_q, last_d;
`else
  logic unused_last;
  assign unused_last = ^REQ_LAST;
`endif
  always_comb begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
    elig = lock_q ? (REQ & grant_q) : REQ;
`else
    elig = REQ;
`endif
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    nxt = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    grant_d = grant_q;
    ack_d = '0;
    csn_d = 1'b1;
    wen_d = 1'b1;
    data_d = data_q;
    cnt_d = cnt_q;
`ifdef UART_TX_ARB_PKT_LOCK_EN
    lock_d = lock_q;
    last_d = last_q;
`endif
    case (state_q)
      IDLE: if (UART_TXRDY && found) begin
        state_d = WRITE;
        win_d = sel;
        grant_d = NUM_REQ'(1) << sel;
        ack_d = NUM_REQ'(1) << sel;
        csn_d = 1'b0;
        wen_d = 1'b0;
        data_d = REQ_DATA[{sel, 3'b000} +: 8];
`ifdef UART_TX_ARB_PKT_LOCK_EN
        last_d = REQ_LAST[sel];
`endif
      end
      WRITE: begin
        state_d = SETTLE;
        cnt_d = 4'(SETTLE_CYC - 1);
`ifdef UART_TX_ARB_PKT_LOCK_EN
        lock_d = !last_q;
        ptr_d = last_q ? nxt : ptr_q;
`else
        ptr_d = nxt;
`endif
      end
      SETTLE: if (cnt_q == 4'd0) state_d = WAIT_RDY;
              else cnt_d = cnt_q - 4'd1;
      WAIT_RDY: if (UART_TXRDY) begin
        state_d = IDLE;
`ifdef UART_TX_ARB_PKT_LOCK_EN
        grant_d = lock_q ? grant_q : '0;
`else
        grant_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      csn_q <= 1'b1;
      wen_q <= 1'b1;
      data_q <= 8'h00;
      cnt_q <= 4'd0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      lock_q <= 1'b0;
      last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      csn_q <= csn_d;
      wen_q <= wen_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      lock_q <= lock_d;
      last_q <= last_d;
`endif
    end
  end
  assign ACK = ack_q;
  assign GRANT = grant_q;
  assign UART_CSN = csn_q;
  assign UART_WEN = wen_q;
  assign UART_DATA_IN = data_q;
  assign BUSY = state_q != IDLE;
endmodule
